alu_seq_param: RTL and testbench

Parametrised, clocked successor of the 16-bit register-file ALU. It decodes one R-type or I-type instruction at a time and reads operands from an internal register file. It executes AND/OR/XOR/NOR/ADD/SUB/SLT/SLL/SRL, writes the result back, and returns result, overflow and illegal-op status over a valid/ready handshake. It sits between the instruction sequencer and downstream result consumers. The free-running delay model of the previous block is replaced by a 4-state FSM.

---
 rtl/alu_seq_param.sv | 131 +++++++++++++
 tb/tb_alu_seq_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// Sequential register-file ALU: accepts one R/I-type instruction in IDLE and reads its
// operands in READ. It executes and writes back in EXEC, then presents the result in DONE.
//   state | meaning
//   IDLE  | ready for a new instruction
//   READ  | fetch op1/op2 from the register file
//   EXEC  | compute, register outputs, write rd
//   DONE  | result valid, wait for consumer
module alu_seq_param #(
  parameter int WIDTH = 16,
  parameter int AW = 4,
  localparam int INST_W = 5 + 2*AW + WIDTH
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [INST_W-1:0] INST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [WIDTH-1:0]  D_out,
  output logic              Over_Flow,
  output logic              ILLEGAL,
  output logic              OUT_VALID,
  input  logic              OUT_READY
);

  localparam int NREGS = 1 << AW;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

  state_t state, state_nxt;

  logic [INST_W-1:0] inst_q;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [WIDTH-1:0]  op1_q, op2_q;

  logic [4:0]       op_code;
  logic [3:0]       funct;
  logic             itype;
  logic [AW-1:0]    rd, rs, rt;
  logic [WIDTH-1:0] imm;

  logic [WIDTH-1:0] res;
  logic             ovf, ill;

  assign op_code = inst_q[INST_W-1 -: 5];
  assign funct   = op_code[4:1];
  assign itype   = op_code[0];
  assign rd      = inst_q[INST_W-6 -: AW];
  assign rs      = inst_q[INST_W-6-AW -: AW];
  assign imm     = inst_q[WIDTH-1:0];
  assign rt      = imm[WIDTH-1 -: AW];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (IN_VALID) state_nxt = READ;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      inst_q <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else begin
      if (state == IDLE && IN_VALID) inst_q <= INST;
      if (state == READ) begin
        // R0 is never written, so it reads as zero without a special case
        op1_q <= regs[rs];
        op2_q <= itype ? imm : regs[rt];
      end
    end
  end

  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (funct)
      4'b0000: res = op1_q & op2_q;
      4'b0001: res = op1_q | op2_q;
      4'b0010: begin
        res = op1_q + op2_q;
        ovf = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (res[WIDTH-1] != op1_q[WIDTH-1]);
      end
      4'b0011: res = op1_q ^ op2_q;
      4'b0100: res = op1_q << op2_q[SW-1:0];
      4'b0101: res = op1_q >> op2_q[SW-1:0];
      4'b0110: begin
        res = op1_q - op2_q;
        ovf = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (res[WIDTH-1] != op1_q[WIDTH-1]);
      end
      4'b0111: res = {{(WIDTH-1){1'b0}}, ($signed(op1_q) < $signed(op2_q))};
      4'b1100: res = ~(op1_q | op2_q);
      default: ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      D_out     <= '0;
      Over_Flow <= 1'b0;
      ILLEGAL   <= 1'b0;
    end else if (state == EXEC) begin
      D_out     <= res;
      Over_Flow <= ovf;
      ILLEGAL   <= ill;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == EXEC && !ill && rd != '0) begin
      regs[rd] <= res;
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: hand-computed vectors for each op, handshake timing,
// back-pressure and asynchronous reset.
module tb_alu_seq_param;

  localparam int WIDTH = 16;
  localparam int AW = 4;
  localparam int INST_W = 5 + 2*AW + WIDTH;

  localparam logic [3:0] F_AND = 4'b0000, F_OR = 4'b0001, F_ADD = 4'b0010, F_XOR = 4'b0011;
  localparam logic [3:0] F_SLL = 4'b0100, F_SRL = 4'b0101, F_SUB = 4'b0110, F_SLT = 4'b0111;
  localparam logic [3:0] F_NOR = 4'b1100, F_BAD = 4'b1111;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic [INST_W-1:0] INST;
  logic              IN_VALID;
  logic              IN_READY;
  logic [WIDTH-1:0]  D_out;
  logic              Over_Flow;
  logic              ILLEGAL;
  logic              OUT_VALID;
  logic              OUT_READY;

  int errors = 0;
  int checks = 0;

  alu_seq_param #(.WIDTH(WIDTH), .AW(AW)) dut (
    .CLK(CLK), .RST_n(RST_n), .INST(INST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D_out(D_out), .Over_Flow(Over_Flow), .ILLEGAL(ILLEGAL), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [INST_W-1:0] mk_i(input logic [3:0] f, input logic [3:0] rd,
                                             input logic [3:0] rs, input logic [15:0] imm);
    return {f, 1'b1, rd, rs, imm};
  endfunction

  function automatic logic [INST_W-1:0] mk_r(input logic [3:0] f, input logic [3:0] rd,
                                             input logic [3:0] rs, input logic [3:0] rt);
    return {f, 1'b0, rd, rs, rt, 12'h000};
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (IN_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready timeout got %b exp 1", nm, IN_READY);
    end
  endtask

  // Accept on edge N; READ after N, EXEC after N+1, DONE (OUT_VALID) after N+2.
  task automatic issue(input logic [INST_W-1:0] inst, input logic [WIDTH-1:0] ed,
                       input logic eo, input logic ei, input string nm);
    @(negedge CLK);
    wait_ready(nm);
    INST = inst;
    IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL %s read_phase got ov=%b ir=%b exp ov=0 ir=0", nm, OUT_VALID, IN_READY);
    end
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s exec_phase out_valid got %b exp 0", nm, OUT_VALID);
    end
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || D_out !== ed || Over_Flow !== eo || ILLEGAL !== ei) begin
      errors++;
      $display("FAIL %s result got ov=%b d=%h of=%b il=%b exp ov=1 d=%h of=%b il=%b",
               nm, OUT_VALID, D_out, Over_Flow, ILLEGAL, ed, eo, ei);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s handoff got ir=%b ov=%b exp ir=1 ov=0", nm, IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || D_out !== '0 || Over_Flow !== 1'b0 ||
        ILLEGAL !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ir=%b ov=%b d=%h of=%b il=%b exp ir=1 ov=0 d=0 of=0 il=0",
               IN_READY, OUT_VALID, D_out, Over_Flow, ILLEGAL);
    end
  endtask

  task automatic test_add_chain();
    issue(mk_i(F_ADD, 1, 0, 16'd10), 16'd10, 1'b0, 1'b0, "addi_r1");
    issue(mk_i(F_ADD, 2, 0, 16'd20), 16'd20, 1'b0, 1'b0, "addi_r2");
    issue(mk_r(F_ADD, 3, 1, 2), 16'd30, 1'b0, 1'b0, "add_r3");
  endtask

  task automatic test_overflow();
    issue(mk_i(F_ADD, 4, 0, 16'h7FFF), 16'h7FFF, 1'b0, 1'b0, "addi_r4");
    issue(mk_i(F_ADD, 5, 0, 16'h0001), 16'h0001, 1'b0, 1'b0, "addi_r5");
    issue(mk_r(F_ADD, 6, 4, 5), 16'h8000, 1'b1, 1'b0, "add_ovf");
    issue(mk_r(F_SUB, 7, 0, 5), 16'hFFFF, 1'b0, 1'b0, "sub_neg");
    issue(mk_r(F_SUB, 13, 6, 5), 16'h7FFF, 1'b1, 1'b0, "sub_ovf");
    issue(mk_r(F_ADD, 13, 7, 5), 16'h0000, 1'b0, 1'b0, "add_wrap");
  endtask

  task automatic test_logic_shift();
    issue(mk_r(F_SLT, 8, 7, 5), 16'h0001, 1'b0, 1'b0, "slt_neg");
    issue(mk_r(F_SLT, 13, 5, 7), 16'h0000, 1'b0, 1'b0, "slt_pos");
    issue(mk_i(F_SLL, 9, 5, 16'd15), 16'h8000, 1'b0, 1'b0, "sll_15");
    issue(mk_i(F_SRL, 10, 9, 16'd15), 16'h0001, 1'b0, 1'b0, "srl_15");
    issue(mk_r(F_AND, 13, 3, 1), 16'h000A, 1'b0, 1'b0, "and");
    issue(mk_r(F_XOR, 13, 3, 1), 16'h0014, 1'b0, 1'b0, "xor");
    issue(mk_r(F_NOR, 13, 0, 0), 16'hFFFF, 1'b0, 1'b0, "nor");
  endtask

  task automatic test_r0_illegal();
    issue(mk_i(F_ADD, 0, 0, 16'd5), 16'd5, 1'b0, 1'b0, "addi_r0");
    issue(mk_r(F_OR, 11, 0, 0), 16'd0, 1'b0, 1'b0, "or_r0");
    issue(mk_r(F_SUB, 13, 6, 5), 16'h7FFF, 1'b1, 1'b0, "sub_ovf2");
    issue(mk_r(F_BAD, 3, 3, 3), 16'd0, 1'b0, 1'b1, "illegal");
    issue(mk_r(F_OR, 12, 3, 0), 16'd30, 1'b0, 1'b0, "or_r3_kept");
  endtask

  task automatic test_back_pressure();
    @(negedge CLK);
    wait_ready("bp_first");
    INST = mk_i(F_ADD, 15, 0, 16'h1234);
    IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    INST = mk_i(F_ADD, 15, 0, 16'h5555);
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (OUT_VALID !== 1'b1 || D_out !== 16'h1234 || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got ov=%b d=%h ir=%b exp ov=1 d=1234 ir=0",
                 i, OUT_VALID, D_out, IN_READY);
      end
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", IN_READY, OUT_VALID);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b1 || D_out !== 16'h5555) begin
      errors++;
      $display("FAIL bp_second got ov=%b d=%h exp ov=1 d=5555", OUT_VALID, D_out);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    issue(mk_r(F_OR, 14, 15, 0), 16'h5555, 1'b0, 1'b0, "bp_readback");
  endtask

  task automatic test_reset_mid_op();
    issue(mk_r(F_SUB, 13, 6, 5), 16'h7FFF, 1'b1, 1'b0, "pre_reset");
    @(negedge CLK);
    wait_ready("rst_issue");
    INST = mk_i(F_ADD, 13, 0, 16'd7);
    IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST_n = 1'b0;
    #1;
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || D_out !== '0 || Over_Flow !== 1'b0 ||
        ILLEGAL !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got ir=%b ov=%b d=%h of=%b il=%b exp ir=1 ov=0 d=0 of=0 il=0",
               IN_READY, OUT_VALID, D_out, Over_Flow, ILLEGAL);
    end
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    issue(mk_r(F_OR, 14, 13, 0), 16'd0, 1'b0, 1'b0, "r13_aborted");
    issue(mk_r(F_OR, 14, 3, 0), 16'd0, 1'b0, 1'b0, "r3_cleared");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    INST = '0;
    repeat (3) @(negedge CLK);
    test_reset();
    RST_n = 1'b1;
    test_add_chain();
    test_overflow();
    test_logic_shift();
    test_r0_illegal();
    test_back_pressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
